// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared types, constants and edge helper for the trigger processor
package trigger_pkg;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_WIDTH_W     = 10;
    localparam int DEF_HOLD_W      = 4;
    localparam int DEF_IDX_W       = 8;
    localparam int DEF_MISS_W      = 8;
    localparam int DEF_TS_W        = 32;

    typedef enum logic {
        ST_ARMED   = 1'b0,
        ST_HOLDOFF = 1'b1
    } ch_state_t;

    // Mode 2'b11 is treated as rising, same as 2'b00.
    function automatic logic edge_hit(input logic [1:0] mode, input logic cur, input logic prev);
        case (mode)
            EDGE_FALL: edge_hit = prev & ~cur;
            EDGE_BOTH: edge_hit = prev ^ cur;
            default:   edge_hit = cur & ~prev;
        endcase
    endfunction

endpackage

// File: rtl/trigger_channel.sv
// rtl/trigger_channel.sv - one trigger channel: sync, priming, edge detect, holdoff FSM, gate, counters
// Ports: clk/rst; trig raw input; enable; edge_mode; trigger_width; holdoff_ticks; cycle_tick;
//        ts_now timestamp source; gate_out/gate_active gate; start pulse; armed; index; missed; timestamp.
// Optional: TRIG_TIMESTAMP_EN enables the timestamp latch, otherwise timestamp is 0.
module trigger_channel
    import trigger_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int WIDTH_W     = DEF_WIDTH_W,
    parameter int HOLD_W      = DEF_HOLD_W,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int MISS_W      = DEF_MISS_W,
    parameter int TS_W        = DEF_TS_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trig,
    input  logic               enable,
    input  logic [1:0]         edge_mode,
    input  logic [WIDTH_W-1:0] trigger_width,
    input  logic [HOLD_W-1:0]  holdoff_ticks,
    input  logic               cycle_tick,
    input  logic [TS_W-1:0]    ts_now,
    output logic               gate_out,
    output logic               gate_active,
    output logic               start,
    output logic               armed,
    output logic [IDX_W-1:0]   index,
    output logic [MISS_W-1:0]  missed,
    output logic [TS_W-1:0]    timestamp
);

    // Priming length covers synchroniser fill plus the history flop.
    localparam int PRIME = SYNC_STAGES + 1;
    localparam int PW    = $clog2(PRIME + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [PW-1:0]          prime_cnt;
    logic                   prime_done;
    logic                   edge_c;
    logic                   edge_q1;
    logic                   edge_q2;
    logic                   accept;
    logic                   miss;
    ch_state_t              state;
    ch_state_t              state_next;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [WIDTH_W-1:0]     wcnt;

    assign prime_done = (prime_cnt == PW'(PRIME));
    assign edge_c     = prime_done & edge_hit(edge_mode, sync_q[SYNC_STAGES-1], hist_q);

    // Two pipeline stages after the compare set the start latency to SYNC_STAGES+2.
    assign accept = edge_q2 & enable & (state == ST_ARMED);
    assign miss   = edge_q2 & enable & (state == ST_HOLDOFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            hist_q    <= 1'b0;
            prime_cnt <= '0;
            edge_q1   <= 1'b0;
            edge_q2   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], trig};
            hist_q  <= sync_q[SYNC_STAGES-1];
            edge_q1 <= edge_c;
            edge_q2 <= edge_q1;
            if (!prime_done) begin
                prime_cnt <= prime_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ARMED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = ST_ARMED;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (accept && (holdoff_ticks != '0)) begin
                        state_next = ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (cycle_tick && (hold_cnt <= HOLD_W'(1))) begin
                        state_next = ST_ARMED;
                    end
                end
                default: state_next = ST_ARMED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            wcnt     <= '0;
            start    <= 1'b0;
            index    <= '0;
            missed   <= '0;
        end else begin
            start <= accept;
            if (!enable) begin
                hold_cnt <= '0;
                wcnt     <= '0;
            end else begin
                if (accept) begin
                    hold_cnt <= holdoff_ticks;
                end else if ((state == ST_HOLDOFF) && cycle_tick && (hold_cnt != '0)) begin
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                end
                // A re-trigger reloads rather than extends the gate.
                if (accept) begin
                    wcnt <= trigger_width;
                end else if (wcnt != '0) begin
                    wcnt <= wcnt - WIDTH_W'(1);
                end
            end
            if (accept) begin
                index <= index + IDX_W'(1);
            end
            if (miss && (missed != '1)) begin
                missed <= missed + MISS_W'(1);
            end
        end
    end

`ifdef TRIG_TIMESTAMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timestamp <= '0;
        end else if (accept) begin
            timestamp <= ts_now;
        end
    end
`else
    logic ts_unused;
    assign ts_unused = ^ts_now;
    assign timestamp = '0;
`endif

    assign gate_active = (wcnt != '0);
    assign gate_out    = enable ? gate_active : 1'b1;
    assign armed       = (state == ST_ARMED);

endmodule

// File: rtl/trigger_processor_mc.sv
// rtl/trigger_processor_mc.sv - multi-channel trigger processor top
// Ports: clk, rst (async high); trig_in, ch_enable per channel; edge_mode, trigger_width,
//        holdoff_ticks, cycle_tick shared; trigger_out, trigger_start, armed per channel;
//        trigger_any, first_ch, first_valid; packed trigger_index, missed_cnt, trig_timestamp.
// Optional: TRIG_TIMESTAMP_EN adds a free-running timestamp counter.
module trigger_processor_mc
    import trigger_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int WIDTH_W     = DEF_WIDTH_W,
    parameter int HOLD_W      = DEF_HOLD_W,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int MISS_W      = DEF_MISS_W,
    parameter int TS_W        = DEF_TS_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        trig_in,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [1:0]               edge_mode,
    input  logic [WIDTH_W-1:0]       trigger_width,
    input  logic [HOLD_W-1:0]        holdoff_ticks,
    input  logic                     cycle_tick,
    output logic [NUM_CH-1:0]        trigger_out,
    output logic [NUM_CH-1:0]        trigger_start,
    output logic                     trigger_any,
    output logic [3:0]               first_ch,
    output logic                     first_valid,
    output logic [NUM_CH-1:0]        armed,
    output logic [NUM_CH*IDX_W-1:0]  trigger_index,
    output logic [NUM_CH*MISS_W-1:0] missed_cnt,
    output logic [NUM_CH*TS_W-1:0]   trig_timestamp
);

    logic [NUM_CH-1:0] gate_active;
    logic [TS_W-1:0]   ts_now;

`ifdef TRIG_TIMESTAMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_now <= '0;
        end else begin
            ts_now <= ts_now + TS_W'(1);
        end
    end
`else
    assign ts_now = '0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        trigger_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .WIDTH_W     (WIDTH_W),
            .HOLD_W      (HOLD_W),
            .IDX_W       (IDX_W),
            .MISS_W      (MISS_W),
            .TS_W        (TS_W)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .trig          (trig_in[i]),
            .enable        (ch_enable[i]),
            .edge_mode     (edge_mode),
            .trigger_width (trigger_width),
            .holdoff_ticks (holdoff_ticks),
            .cycle_tick    (cycle_tick),
            .ts_now        (ts_now),
            .gate_out      (trigger_out[i]),
            .gate_active   (gate_active[i]),
            .start         (trigger_start[i]),
            .armed         (armed[i]),
            .index         (trigger_index[i*IDX_W +: IDX_W]),
            .missed        (missed_cnt[i*MISS_W +: MISS_W]),
            .timestamp     (trig_timestamp[i*TS_W +: TS_W])
        );
    end

    // Disabled channels pass trigger_out high but never count as active.
    assign trigger_any = |(gate_active & ch_enable);

    always_comb begin
        first_ch    = 4'd0;
        first_valid = |trigger_start;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (trigger_start[i]) begin
                first_ch = 4'(i);
            end
        end
    end

endmodule

// File: tb/tb_trigger_processor_mc.sv
// tb/tb_trigger_processor_mc.sv - scoreboard testbench for trigger_processor_mc
module tb_trigger_processor_mc;

    localparam int NUM_CH = 4;
    localparam int SYNC   = 2;
    localparam int WW     = 10;
    localparam int HW     = 4;
    localparam int IW     = 8;
    localparam int MW     = 8;
    localparam int TW     = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] trig_in;
    logic [NUM_CH-1:0] ch_enable;
    logic [1:0]        edge_mode;
    logic [WW-1:0]     trigger_width;
    logic [HW-1:0]     holdoff_ticks;
    logic              cycle_tick;
    logic [NUM_CH-1:0] trigger_out;
    logic [NUM_CH-1:0] trigger_start;
    logic              trigger_any;
    logic [3:0]        first_ch;
    logic              first_valid;
    logic [NUM_CH-1:0] armed;
    logic [NUM_CH*IW-1:0] trigger_index;
    logic [NUM_CH*MW-1:0] missed_cnt;
    logic [NUM_CH*TW-1:0] trig_timestamp;

    trigger_processor_mc #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .WIDTH_W(WW), .HOLD_W(HW),
        .IDX_W(IW), .MISS_W(MW), .TS_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .trig_in(trig_in), .ch_enable(ch_enable),
        .edge_mode(edge_mode), .trigger_width(trigger_width),
        .holdoff_ticks(holdoff_ticks), .cycle_tick(cycle_tick),
        .trigger_out(trigger_out), .trigger_start(trigger_start),
        .trigger_any(trigger_any), .first_ch(first_ch), .first_valid(first_valid),
        .armed(armed), .trigger_index(trigger_index), .missed_cnt(missed_cnt),
        .trig_timestamp(trig_timestamp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int idx;
        int cyc;
    } sb_item_t;

    sb_item_t sb[$];
    int       exp_idx [NUM_CH];
    int       cyc = 0;
    int       n_cmp = 0;
    int       n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Expected start lands SYNC+2 edges after the sampling edge, which is the next posedge.
    task automatic drive(input int ch, input logic lvl, input bit acc);
        sb_item_t e;
        trig_in[ch] = lvl;
        if (acc) begin
            exp_idx[ch] = (exp_idx[ch] + 1) % (1 << IW);
            e.ch  = ch;
            e.idx = exp_idx[ch];
            e.cyc = cyc + SYNC + 3;
            sb.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_high(input int ch, input int n, output int hi, output int any_hi);
        hi = 0;
        any_hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (trigger_out[ch]) hi++;
            if (trigger_any) any_hi++;
        end
    endtask

    always @(negedge clk) begin
        sb_item_t e;
        bit first;
        if (!rst && trigger_start != '0) begin
            first = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (trigger_start[i]) begin
                    if (sb.size() == 0) begin
                        chk_eq("spurious_start", 64'(trigger_start), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk_eq("start_ch", 64'(i), 64'(e.ch));
                        chk_eq("start_idx", 64'(trigger_index[i*IW +: IW]), 64'(e.idx));
                        chk_eq("start_latency", 64'(cyc), 64'(e.cyc));
                        if (first) begin
                            chk_eq("first_ch", 64'(first_ch), 64'(e.ch));
                            chk_eq("first_valid", 64'(first_valid), 64'd1);
                            first = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int hi, any_hi, n;
        logic [TW-1:0] ts1, ts2;
        for (int i = 0; i < NUM_CH; i++) exp_idx[i] = 0;
        rst = 1'b1;
        trig_in = 4'b0001;
        ch_enable = 4'hF;
        edge_mode = 2'b00;
        trigger_width = 10'd3;
        holdoff_ticks = 4'd0;
        cycle_tick = 1'b0;
        wait_cyc(3);
        chk_eq("rst_armed", 64'(armed), 64'hF);
        chk_eq("rst_start", 64'(trigger_start), 64'd0);
        chk_eq("rst_first_valid", 64'(first_valid), 64'd0);
        chk_eq("rst_first_ch", 64'(first_ch), 64'd0);
        chk_eq("rst_index", 64'(trigger_index), 64'd0);
        chk_eq("rst_missed", 64'(missed_cnt), 64'd0);
        chk_eq("rst_trigger_out", 64'(trigger_out), 64'd0);
        chk_eq("rst_trigger_any", 64'(trigger_any), 64'd0);
        chk_eq("rst_timestamp", 64'(|trig_timestamp), 64'd0);
        rst = 1'b0;

        // Input already high at release must not trigger.
        wait_cyc(20);
        chk_eq("prime_no_index", 64'(trigger_index[0 +: IW]), 64'd0);
        drive(0, 1'b0, 1'b0);
        wait_cyc(6);
        drive(0, 1'b1, 1'b1);
        wait_cyc(10);
        chk_eq("prime_index", 64'(trigger_index[0 +: IW]), 64'd1);

        // Gate width 5, then width 0 with index still counting.
        trigger_width = 10'd5;
        drive(1, 1'b1, 1'b1);
        count_high(1, 15, hi, any_hi);
        chk_eq("gate_w5", 64'(hi), 64'd5);
        chk_eq("any_w5", 64'(any_hi), 64'd5);
        drive(1, 1'b0, 1'b0);
        wait_cyc(6);
        trigger_width = 10'd0;
        drive(1, 1'b1, 1'b1);
        count_high(1, 12, hi, any_hi);
        chk_eq("gate_w0", 64'(hi), 64'd0);
        chk_eq("index_w0", 64'(trigger_index[IW +: IW]), 64'd2);

        // Holdoff 2 with ticks 10 cycles apart.
        trigger_width = 10'd1;
        edge_mode = 2'b10;
        holdoff_ticks = 4'd2;
        drive(0, 1'b0, 1'b1);
        wait_cyc(3);
        drive(0, 1'b1, 1'b0);
        wait_cyc(3);
        drive(0, 1'b0, 1'b0);
        wait_cyc(4);
        cycle_tick = 1'b1;
        wait_cyc(1);
        cycle_tick = 1'b0;
        wait_cyc(2);
        chk_eq("holdoff_armed_mid", 64'(armed[0]), 64'd0);
        chk_eq("holdoff_missed", 64'(missed_cnt[0 +: MW]), 64'd2);
        wait_cyc(7);
        cycle_tick = 1'b1;
        wait_cyc(1);
        cycle_tick = 1'b0;
        wait_cyc(2);
        chk_eq("holdoff_rearmed", 64'(armed[0]), 64'd1);
        holdoff_ticks = 4'd0;
        drive(0, 1'b1, 1'b1);
        wait_cyc(8);
        chk_eq("holdoff_missed_kept", 64'(missed_cnt[0 +: MW]), 64'd2);

        // Both edges, then falling only, on ch2.
        for (int k = 0; k < 4; k++) begin
            drive(2, (k % 2 == 0), 1'b1);
            wait_cyc(4);
        end
        wait_cyc(6);
        chk_eq("both_index", 64'(trigger_index[2*IW +: IW]), 64'd4);
        edge_mode = 2'b01;
        for (int k = 0; k < 4; k++) begin
            drive(2, (k % 2 == 0), (k % 2 == 1));
            wait_cyc(4);
        end
        wait_cyc(6);
        chk_eq("fall_index", 64'(trigger_index[2*IW +: IW]), 64'd6);

        // Disabled channel passes high and stays out of trigger_any.
        edge_mode = 2'b00;
        ch_enable = 4'b0111;
        wait_cyc(1);
        chk_eq("dis_out_high", 64'(trigger_out[3]), 64'd1);
        chk_eq("dis_any", 64'(trigger_any), 64'd0);
        drive(3, 1'b1, 1'b0);
        count_high(3, 10, hi, any_hi);
        chk_eq("dis_any_window", 64'(any_hi), 64'd0);
        chk_eq("dis_index", 64'(trigger_index[3*IW +: IW]), 64'd0);
        ch_enable = 4'hF;
        drive(1, 1'b0, 1'b0);
        drive(3, 1'b0, 1'b0);
        wait_cyc(6);
        drive(1, 1'b1, 1'b1);
        drive(3, 1'b1, 1'b1);
        wait_cyc(10);

        // Index wrap on ch0.
        edge_mode = 2'b10;
        n = (1 << IW) - exp_idx[0];
        for (int k = 0; k < n; k++) begin
            drive(0, ~trig_in[0], 1'b1);
            wait_cyc(2);
        end
        wait_cyc(8);
        chk_eq("index_wrap", 64'(trigger_index[0 +: IW]), 64'd0);

`ifdef TRIG_TIMESTAMP_EN
        drive(0, ~trig_in[0], 1'b1);
        wait_cyc(8);
        ts1 = trig_timestamp[0 +: TW];
        wait_cyc(92);
        drive(0, ~trig_in[0], 1'b1);
        wait_cyc(8);
        ts2 = trig_timestamp[0 +: TW];
        chk_eq("ts_delta", 64'(ts2 - ts1), 64'd100);
`else
        ts1 = trig_timestamp[0 +: TW];
        ts2 = trig_timestamp[TW +: TW];
        chk_eq("ts_zero", 64'(ts1 | ts2), 64'd0);
`endif

        wait_cyc(4);
        chk_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
